// File: rtl/cnn_mac_engine_if.sv
// Valid/ready stream bundle for the MAC engine: packed activation/weight beats in,
// one saturated result out.
interface cnn_mac_engine_if #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [N_IN*DATA_W-1:0]   in_data;
  logic [N_IN*DATA_W-1:0]   in_weight;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic                     out_sat;

  modport master (
    output in_valid, in_data, in_weight, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, in_weight, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/cnn_mac_engine.sv
// Multi-channel multiply-accumulate engine: per-channel weights, runtime beat count,
// two-stage product/sum pipeline, then ReLU, arithmetic shift and saturation.
//
// state   | meaning
// S_IDLE  | waiting for start with a non-zero cfg_len
// S_ACCUM | accepting beats until cfg_len beats are taken
// S_DRAIN | last beat still in the product/sum pipeline
// S_OUT   | result presented, waiting for out_ready
module cnn_mac_engine #(
  parameter int N_IN   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [3:0]        cfg_shift,
  input  logic              cfg_relu,
  output logic              busy,
  cnn_mac_engine_if.slave   bus
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

  state_t                   state;
  logic [LEN_W-1:0]         beat_cnt;
  logic [LEN_W-1:0]         len_q;
  logic [3:0]               shift_q;
  logic                     relu_q;
  logic                     drain_wait;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] prod [N_IN];
  logic                     s1_valid;

  logic                     beat_acc;
  logic                     last_beat;
  logic [LEN_W:0]           beat_next;
  logic signed [ACC_W-1:0]  prod_sum;
  logic signed [ACC_W-1:0]  relu_v;
  logic signed [ACC_W-1:0]  shift_v;
  logic [OUT_W-1:0]         res_data;
  logic                     res_sat;

  assign beat_acc  = bus.in_valid && bus.in_ready;
  // one extra bit so cfg_len = all-ones compares before the counter could wrap
  assign beat_next = {1'b0, beat_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign last_beat = (beat_next == {1'b0, len_q});

  always_comb begin
    prod_sum = '0;
    for (int k = 0; k < N_IN; k++) begin
      prod_sum = prod_sum + {{(ACC_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
    end
  end

  always_comb begin
    relu_v  = (relu_q && acc[ACC_W-1]) ? '0 : acc;
    shift_v = relu_v >>> shift_q;
    res_sat = 1'b0;
    if (shift_v > SAT_MAX) begin
      res_data = SAT_MAX[OUT_W-1:0];
      res_sat  = 1'b1;
    end else if (shift_v < SAT_MIN) begin
      res_data = SAT_MIN[OUT_W-1:0];
      res_sat  = 1'b1;
    end else begin
      res_data = shift_v[OUT_W-1:0];
    end
  end

  // Stage 1: per-channel products of the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      for (int k = 0; k < N_IN; k++) prod[k] <= '0;
    end else begin
      s1_valid <= beat_acc;
      if (beat_acc) begin
        for (int k = 0; k < N_IN; k++) begin
          prod[k] <= $signed(bus.in_data[k*DATA_W +: DATA_W]) *
                     $signed(bus.in_weight[k*DATA_W +: DATA_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      beat_cnt      <= '0;
      len_q         <= '0;
      shift_q       <= '0;
      relu_q        <= 1'b0;
      drain_wait    <= 1'b0;
      acc           <= '0;
      busy          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else begin
      // Stage 2: wrapping accumulate of the summed products
      if (s1_valid) acc <= acc + prod_sum;

      case (state)
        S_IDLE: begin
          if (start && (cfg_len != '0)) begin
            len_q        <= cfg_len;
            shift_q      <= cfg_shift;
            relu_q       <= cfg_relu;
            acc          <= '0;
            beat_cnt     <= '0;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            state        <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (beat_acc) begin
            beat_cnt <= beat_next[LEN_W-1:0];
            if (last_beat) begin
              bus.in_ready <= 1'b0;
              drain_wait   <= 1'b1;
              state        <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // first cycle: last product in stage 1; second: accumulator is final
          if (drain_wait) begin
            drain_wait <= 1'b0;
          end else begin
            bus.out_data  <= res_data;
            bus.out_sat   <= res_sat;
            bus.out_valid <= 1'b1;
            state         <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_mac_engine.sv
// Scoreboard bench for cnn_mac_engine: expected results queued as kernels are driven,
// popped and compared when out_valid appears.
module tb_cnn_mac_engine;
  localparam int N_IN   = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int LEN_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [3:0]       cfg_shift = '0;
  logic             cfg_relu = 1'b0;
  logic             busy;

  cnn_mac_engine_if #(.N_IN(N_IN), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  cnn_mac_engine #(
    .N_IN(N_IN), .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint sat;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint model_acc;
  int     d_v[N_IN];
  int     w_v[N_IN];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input longint acc, input int sh, input bit relu);
    exp_t   e;
    longint v, hi, lo;
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo = -(longint'(1) <<< (OUT_W - 1));
    v  = acc;
    if (relu && v < 0) v = 0;
    v = v >>> sh;
    if (v > hi) begin
      e.data = hi; e.sat = 1;
    end else if (v < lo) begin
      e.data = lo; e.sat = 1;
    end else begin
      e.data = v;  e.sat = 0;
    end
    return e;
  endfunction

  function automatic exp_t lit(input longint d, input longint s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    return e;
  endfunction

  task automatic start_kernel(input int len, input int sh, input bit relu);
    @(negedge clk);
    start = 1'b1; cfg_len = LEN_W'(len); cfg_shift = 4'(sh); cfg_relu = relu;
    @(negedge clk);
    start = 1'b0;
    model_acc = 0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", bus.in_ready, 1);
  endtask

  task automatic send_beat(input int gap);
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    for (int k = 0; k < N_IN; k++) begin
      bus.in_data[k*DATA_W +: DATA_W]   = DATA_W'(d_v[k]);
      bus.in_weight[k*DATA_W +: DATA_W] = DATA_W'(w_v[k]);
      model_acc += longint'(d_v[k]) * longint'(w_v[k]);
    end
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // called at the first falling edge after the final beat was accepted
  task automatic wait_result();
    int lat = 1;
    chk("in_ready_drop", bus.in_ready, 0);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
  endtask

  task automatic take_result();
    exp_t e;
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk("out_data", $signed(bus.out_data), e.data);
    chk("out_sat", bus.out_sat, e.sat);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_drop", bus.out_valid, 0);
    chk("busy_drop", busy, 0);
  endtask

  task automatic run_len1(input int sh, input bit relu, input exp_t e);
    start_kernel(1, sh, relu);
    send_beat(0);
    sb.push_back(e);
    wait_result();
    take_result();
  endtask

  initial begin
    int ov_seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b1;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_sat", bus.out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", bus.out_data, 0);
    rst = 1'b0;

    d_v = '{5, 6, 7, 8}; w_v = '{3, 3, 3, 3};
    run_len1(0, 0, lit(78, 0));

    for (int s = 0; s < 2; s++) begin
      start_kernel(3, (s == 0) ? 0 : 2, 0);
      repeat (3) send_beat(2);
      sb.push_back((s == 0) ? lit(127, 1) : lit(58, 0));
      wait_result();
      take_result();
    end

    w_v = '{-3, -3, -3, -3};
    run_len1(0, 0, lit(-78, 0));
    run_len1(0, 1, lit(0, 0));

    d_v = '{-128, -128, -128, -128}; w_v = '{-128, -128, -128, -128};
    run_len1(0, 0, lit(127, 1));
    d_v = '{127, 127, 127, 127};
    run_len1(0, 0, lit(-128, 1));

    // backpressure with an ignored start while the result is held
    bus.out_ready = 1'b0;
    d_v = '{5, 6, 7, 8}; w_v = '{3, 3, 3, 3};
    start_kernel(1, 0, 0);
    send_beat(0);
    sb.push_back(lit(78, 0));
    wait_result();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin start = 1'b1; cfg_len = 8'd1; end
      if (i == 5) start = 1'b0;
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_data", $signed(bus.out_data), 78);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    take_result();
    @(negedge clk);
    chk("bp_busy_idle", busy, 0);

    // longest kernel: the counter must reach the terminal compare without wrapping
    d_v = '{1, 1, 1, 1}; w_v = '{1, 1, 1, 1};
    start_kernel(255, 3, 0);
    repeat (255) send_beat(0);
    sb.push_back(model(model_acc, 3, 0));
    wait_result();
    take_result();

    for (int r = 0; r < 4; r++) begin
      int len, sh;
      bit relu;
      len  = $urandom_range(1, 6);
      sh   = $urandom_range(0, 9);
      relu = 1'($urandom_range(0, 1));
      start_kernel(len, sh, relu);
      for (int b = 0; b < len; b++) begin
        for (int k = 0; k < N_IN; k++) begin
          d_v[k] = int'($urandom_range(0, 255)) - 128;
          w_v[k] = int'($urandom_range(0, 255)) - 128;
        end
        send_beat($urandom_range(0, 2));
      end
      sb.push_back(model(model_acc, sh, relu));
      wait_result();
      take_result();
    end

    // reset in the middle of accumulation
    d_v = '{5, 6, 7, 8}; w_v = '{3, 3, 3, 3};
    start_kernel(4, 0, 0);
    repeat (2) send_beat(0);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_sat", bus.out_sat, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    ov_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    chk("midrst_no_out_valid", ov_seen, 0);

    // zero-length start is ignored
    @(negedge clk);
    start = 1'b1; cfg_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy", busy, 0);
    chk("len0_in_ready", bus.in_ready, 0);
    @(negedge clk);
    chk("len0_busy_later", busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cnn_mac_engine.md
# cnn_mac_engine

Parametrised multiply-accumulate engine for the CNN accelerator datapath. It generalises the fixed 4-input, 8-bit, single-weight convolution unit:
- channel count, data width and accumulator width are parameters;
- each channel has its own weight;
- a kernel can be accumulated over a runtime-configured number of beats;
- optional ReLU, output shift and saturation are applied before the result is presented;
- input and output use valid/ready handshakes.

## Interface
Parameters
- N_IN, 4, number of parallel input channels (≥1)
- DATA_W, 8, signed activation and weight width
- ACC_W, 24, signed accumulator width (must be ≥ 2*DATA_W + clog2(N_IN))
- OUT_W, 8, signed result width
- LEN_W, 8, width of the beat-count configuration

Ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a kernel; sampled only in IDLE
- cfg_len  in  LEN_W  number of beats to accumulate; latched on start
- cfg_shift  in  4  arithmetic right-shift amount; latched on start
- cfg_relu  in  1  1 = clamp negative results to 0; latched on start
- in_valid  in  1  in_data/in_weight valid
- in_ready  out  1  engine accepts a beat this cycle
- in_data  in  N_IN*DATA_W  packed signed activations; channel k at bits [k*DATA_W +: DATA_W]
- in_weight  in  N_IN*DATA_W  packed signed weights, same packing
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed result
- out_sat  out  1  saturation was applied to out_data
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - start=1 with cfg_len≠0: latch the configuration, clear the accumulator and beat counter, go to ACCUM.
  - start=1 with cfg_len=0: ignored; stay in IDLE.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - Beat counter increments per accepted beat.
  - When the cfg_len-th beat is accepted, in_ready drops the next cycle and the engine goes to DRAIN.
  - in_valid gaps are allowed and simply stall.
- Pipeline:
  - Stage 1 registers the N_IN signed products, each 2*DATA_W bits.
  - Stage 2 sums the products (sign-extended to ACC_W) and adds the sum to the accumulator.
  - Accumulator wraps modulo 2^ACC_W; no overflow detection at this stage.
- DRAIN: waits until the last beat has left stage 2 (2 cycles), then computes the result into the output register and goes to OUT.
- Result computation:
  - v = acc.
  - If relu: v = max(v, 0).
  - v = v >>> shift (arithmetic).
  - Saturate to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; out_sat=1 if clamped.
- OUT:
  - out_valid=1; out_data and out_sat are held stable.
  - On out_valid && out_ready, go to IDLE and out_valid drops the next cycle.
- start is ignored in every state other than IDLE.

## Timing
- Reset values:
  - state=IDLE;
  - in_ready, out_valid, out_sat, busy = 0;
  - out_data = 0;
  - accumulator, counter and configuration registers = 0.
- Reset mid-operation (any state) aborts immediately and asynchronously. No out_valid follows.
- start at cycle t: busy=1 and in_ready=1 from t+1.
- Last beat accepted at cycle t:
  - in_ready=0 from t+1;
  - out_valid=1 at t+3 (fixed 3-cycle latency from the final beat to the result).
- out_valid asserted with out_ready already high: handshake completes in that same cycle; IDLE at the next edge. Minimum 1 cycle in OUT.
- out_ready low: out_valid and out_data stay constant indefinitely.
- cfg_len = 2^LEN_W − 1: counter must not wrap before the terminal compare.
- Throughput: one beat per cycle in ACCUM. Back-to-back kernels are separated by the DRAIN and OUT states plus one IDLE cycle for start.

## Test plan
- Basic kernel, cfg_len=1, shift=0, relu=0, data {5,6,7,8}, all weights 3 → out_data=78, out_sat=0, out_valid exactly 3 cycles after beat acceptance.
- Multi-beat, cfg_len=3, same beat three times with in_valid low between beats → out_data=234 saturates to 127 with out_sat=1. Repeat with shift=2 → 58, out_sat=0.
- ReLU, data {5,6,7,8}, weights −3, len 1: relu=0 → out_data=−78 (0xB2); relu=1 → out_data=0, out_sat=0.
- Saturation, data and weights all −128, len 1, shift=0 → acc=65536, out_data=127, out_sat=1. Data 127 with weights −128 → out_data=−128, out_sat=1.
- Backpressure and ignored start:
  - hold out_ready=0 for 10 cycles → out_valid and out_data stable throughout;
  - pulse start while held → no effect;
  - raise out_ready → one transfer, then busy=0.
- Reset and boundaries:
  - assert rst mid-ACCUM after 2 of 4 beats → all outputs 0 immediately, no out_valid afterwards;
  - start with cfg_len=0 → busy stays 0.
